// File: rtl/game_tick_scheduler.sv
// Game-tick scheduler for a snake game: countdown, run/pause/over control and a
// speed level that shortens the number of base ticks between game ticks.
module game_tick_scheduler #(
   parameter int START_DIV       = 8,
   parameter int MIN_DIV         = 2,
   parameter int FOOD_PER_LEVEL  = 4,
   parameter int COUNTDOWN_TICKS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       base_tick,
   input  logic       start,
   input  logic       pause_btn,
   input  logic       food_eaten,
   input  logic       game_over,
   output logic       game_tick,
   output logic [2:0] state,
   output logic [3:0] speed_level,
   output logic [1:0] countdown
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_RUN       = 3'd2,
      S_PAUSED    = 3'd3,
      S_OVER      = 3'd4
   } state_e;

   localparam logic [3:0] START_DIV_L = 4'(START_DIV);
   localparam logic [3:0] MAX_LEVEL_L = 4'(START_DIV - MIN_DIV);
   localparam logic [3:0] FOOD_LAST_L = 4'(FOOD_PER_LEVEL - 1);
   localparam logic [1:0] CD_LOAD_L   = 2'(COUNTDOWN_TICKS);

   state_e     state_q, state_d;
   logic [1:0] countdown_q, countdown_d;
   logic [3:0] sub_cnt_q, sub_cnt_d;
   logic [3:0] food_cnt_q, food_cnt_d;
   logic [3:0] level_q, level_d;
   logic       tick_q, tick_d;
   logic [3:0] tick_limit;

   // Level never exceeds MAX_LEVEL, so the divisor stays at or above MIN_DIV.
   assign tick_limit = START_DIV_L - level_q - 4'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         countdown_q <= 2'd0;
         sub_cnt_q   <= 4'd0;
         food_cnt_q  <= 4'd0;
         level_q     <= 4'd0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         countdown_q <= countdown_d;
         sub_cnt_q   <= sub_cnt_d;
         food_cnt_q  <= food_cnt_d;
         level_q     <= level_d;
         tick_q      <= tick_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      countdown_d = countdown_q;
      sub_cnt_d   = sub_cnt_q;
      food_cnt_d  = food_cnt_q;
      level_d     = level_q;
      tick_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_COUNTDOWN;
               countdown_d = CD_LOAD_L;
               sub_cnt_d   = 4'd0;
               food_cnt_d  = 4'd0;
               level_d     = 4'd0;
            end
         end
         S_COUNTDOWN: begin
            if (base_tick) begin
               if (countdown_q == 2'd1) begin
                  state_d     = S_RUN;
                  countdown_d = 2'd0;
                  sub_cnt_d   = 4'd0;
               end else begin
                  countdown_d = countdown_q - 2'd1;
               end
            end
         end
         S_RUN: begin
            if (game_over) begin
               state_d = S_OVER;
            end else if (pause_btn) begin
               state_d = S_PAUSED;
            end else begin
               // Tick decision uses the level held this cycle, before any food update.
               if (base_tick) begin
                  if (sub_cnt_q >= tick_limit) begin
                     tick_d    = 1'b1;
                     sub_cnt_d = 4'd0;
                  end else begin
                     sub_cnt_d = sub_cnt_q + 4'd1;
                  end
               end
               if (food_eaten) begin
                  if (food_cnt_q == FOOD_LAST_L) begin
                     food_cnt_d = 4'd0;
                     if (level_q < MAX_LEVEL_L) level_d = level_q + 4'd1;
                  end else begin
                     food_cnt_d = food_cnt_q + 4'd1;
                  end
               end
            end
         end
         S_PAUSED: begin
            if (game_over)      state_d = S_OVER;
            else if (pause_btn) state_d = S_RUN;
         end
         S_OVER: begin
            if (start) begin
               state_d     = S_COUNTDOWN;
               countdown_d = CD_LOAD_L;
               sub_cnt_d   = 4'd0;
               food_cnt_d  = 4'd0;
               level_d     = 4'd0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            countdown_d = 2'd0;
            sub_cnt_d   = 4'd0;
            food_cnt_d  = 4'd0;
            level_d     = 4'd0;
         end
      endcase
   end

   assign game_tick   = tick_q;
   assign state       = state_q;
   assign speed_level = level_q;
   assign countdown   = countdown_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: a per-cycle reference model plus
// hand-computed expectations along a scripted game.
module tb_game_tick_scheduler;

   localparam int START_DIV = 8;
   localparam int MIN_DIV   = 2;
   localparam int FPL       = 4;
   localparam int CD_TICKS  = 3;
   localparam int MAX_LEVEL = START_DIV - MIN_DIV;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic base_tick = 1'b0, start = 1'b0, pause_btn = 1'b0;
   logic food_eaten = 1'b0, game_over = 1'b0;
   logic       game_tick_w;
   logic [2:0] state_w;
   logic [3:0] level_w;
   logic [1:0] cd_w;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;
   int t0;

   game_tick_scheduler #(
      .START_DIV(START_DIV), .MIN_DIV(MIN_DIV),
      .FOOD_PER_LEVEL(FPL), .COUNTDOWN_TICKS(CD_TICKS)
   ) dut (
      .clk(clk), .reset(reset), .base_tick(base_tick), .start(start),
      .pause_btn(pause_btn), .food_eaten(food_eaten), .game_over(game_over),
      .game_tick(game_tick_w), .state(state_w), .speed_level(level_w),
      .countdown(cd_w)
   );

   always #5 clk = ~clk;

   // Reference model: game phase as an int, base ticks accumulated since the last game tick,
   // food eaten towards the next level, and the level itself.
   int m_state, m_cd, m_acc, m_food, m_level;
   bit m_tick;

   always @(posedge clk or posedge reset) begin : model
      int ns, ncd, nacc, nfood, nlvl, div;
      bit ntick;
      if (reset) begin
         m_state <= 0; m_cd <= 0; m_acc <= 0; m_food <= 0; m_level <= 0; m_tick <= 1'b0;
      end else begin
         ns = m_state; ncd = m_cd; nacc = m_acc; nfood = m_food; nlvl = m_level; ntick = 1'b0;
         if (m_state == 0 || m_state == 4) begin
            if (start) begin
               ns = 1; ncd = CD_TICKS; nacc = 0; nfood = 0; nlvl = 0;
            end
         end else if (m_state == 1) begin
            if (base_tick) begin
               ncd = m_cd - 1;
               if (ncd == 0) begin ns = 2; nacc = 0; end
            end
         end else if (m_state == 2) begin
            if (game_over) ns = 4;
            else if (pause_btn) ns = 3;
            else begin
               div = START_DIV - m_level;
               if (div < MIN_DIV) div = MIN_DIV;
               if (base_tick) begin
                  if (m_acc + 1 >= div) begin ntick = 1'b1; nacc = 0; end
                  else nacc = m_acc + 1;
               end
               if (food_eaten) begin
                  nfood = (m_food + 1) % FPL;
                  if (nfood == 0 && m_level < MAX_LEVEL) nlvl = m_level + 1;
               end
            end
         end else if (m_state == 3) begin
            if (game_over) ns = 4;
            else if (pause_btn) ns = 2;
         end
         m_state <= ns; m_cd <= ncd; m_acc <= nacc; m_food <= nfood; m_level <= nlvl;
         m_tick <= ntick;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (game_tick_w) tick_cnt++;
      chk("model_state", int'(state_w), m_state);
      chk("model_tick", int'(game_tick_w), int'(m_tick));
      chk("model_level", int'(level_w), m_level);
      chk("model_countdown", int'(cd_w), m_cd);
   end

   task automatic drive(input bit bt, input bit st, input bit pb, input bit fe, input bit go);
      base_tick = bt; start = st; pause_btn = pb; food_eaten = fe; game_over = go;
      @(posedge clk);
      #1;
      base_tick = 1'b0; start = 1'b0; pause_btn = 1'b0; food_eaten = 1'b0; game_over = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
   endtask

   task automatic bt_n(input int n);
      for (int i = 0; i < n; i++) begin drive(1, 0, 0, 0, 0); idle(1); end
   endtask

   task automatic food_n(input int n);
      for (int i = 0; i < n; i++) begin drive(0, 0, 0, 1, 0); idle(1); end
   endtask

   task automatic enter_run();
      drive(0, 1, 0, 0, 0);
      for (int i = 0; i < CD_TICKS; i++) drive(1, 0, 0, 0, 0);
      chk("enter_run_state", int'(state_w), 2);
   endtask

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_state", int'(state_w), 0);
      chk("reset_tick", int'(game_tick_w), 0);
      chk("reset_level", int'(level_w), 0);
      chk("reset_countdown", int'(cd_w), 0);

      t0 = tick_cnt;
      bt_n(5);
      chk("idle_no_tick", tick_cnt - t0, 0);
      chk("idle_state", int'(state_w), 0);

      drive(0, 1, 0, 0, 0);
      chk("cd_load_state", int'(state_w), 1);
      chk("cd_load", int'(cd_w), 3);
      drive(0, 0, 0, 0, 1);
      chk("cd_ignores_over", int'(state_w), 1);
      drive(1, 0, 0, 0, 0);
      chk("cd_2", int'(cd_w), 2);
      drive(1, 0, 0, 0, 0);
      chk("cd_1", int'(cd_w), 1);
      drive(1, 0, 0, 0, 0);
      chk("cd_run_state", int'(state_w), 2);
      chk("cd_run_zero", int'(cd_w), 0);

      t0 = tick_cnt;
      bt_n(7);
      chk("lvl0_no_early_tick", tick_cnt - t0, 0);
      drive(0, 1, 0, 0, 0);
      chk("start_in_run_ignored", int'(state_w), 2);
      drive(1, 0, 0, 0, 0);
      chk("lvl0_tick_8th", int'(game_tick_w), 1);
      idle(1);

      food_n(4);
      chk("level_1", int'(level_w), 1);
      t0 = tick_cnt;
      bt_n(6);
      chk("lvl1_no_early_tick", tick_cnt - t0, 0);
      drive(1, 0, 0, 0, 0);
      chk("lvl1_tick_7th", int'(game_tick_w), 1);
      idle(1);
      t0 = tick_cnt;
      bt_n(7);
      chk("lvl1_period_7", tick_cnt - t0, 1);

      food_n(28);
      chk("level_saturated", int'(level_w), 6);
      drive(1, 0, 0, 0, 0);
      chk("div2_first", int'(game_tick_w), 0);
      idle(1);
      drive(1, 0, 0, 0, 0);
      chk("div2_second", int'(game_tick_w), 1);
      idle(1);

      drive(0, 0, 0, 0, 1);
      chk("over_state", int'(state_w), 4);
      chk("over_holds_level", int'(level_w), 6);
      drive(0, 1, 0, 0, 0);
      chk("restart_level_clear", int'(level_w), 0);
      for (int i = 0; i < CD_TICKS; i++) drive(1, 0, 0, 0, 0);
      food_n(8);
      chk("level_2", int'(level_w), 2);
      t0 = tick_cnt;
      bt_n(5);
      chk("lvl2_sub5_no_tick", tick_cnt - t0, 0);
      food_n(4);
      chk("level_3", int'(level_w), 3);
      drive(1, 0, 0, 0, 0);
      chk("new_div_immediate_tick", int'(game_tick_w), 1);
      idle(1);

      food_n(3);
      t0 = tick_cnt;
      bt_n(3);
      chk("lvl3_sub3_no_tick", tick_cnt - t0, 0);
      drive(1, 0, 0, 1, 0);
      chk("coincident_uses_old_div", int'(game_tick_w), 0);
      chk("coincident_level_4", int'(level_w), 4);
      idle(1);
      drive(1, 0, 0, 0, 0);
      chk("lvl4_tick_after", int'(game_tick_w), 1);
      idle(1);

      drive(0, 0, 0, 0, 1);
      enter_run();
      t0 = tick_cnt;
      bt_n(7);
      chk("pause_setup_no_tick", tick_cnt - t0, 0);
      drive(1, 0, 1, 0, 0);
      chk("pause_wins_tick", int'(game_tick_w), 0);
      chk("pause_state", int'(state_w), 3);
      t0 = tick_cnt;
      bt_n(20);
      drive(0, 0, 0, 1, 0);
      chk("paused_no_ticks", tick_cnt - t0, 0);
      chk("paused_food_ignored", int'(level_w), 0);
      drive(0, 0, 1, 0, 0);
      chk("resume_state", int'(state_w), 2);
      drive(1, 0, 0, 0, 0);
      chk("resume_tick", int'(game_tick_w), 1);
      idle(1);

      food_n(4);
      drive(0, 0, 1, 0, 0);
      chk("pause_again", int'(state_w), 3);
      drive(0, 0, 1, 1, 1);
      chk("over_priority_state", int'(state_w), 4);
      chk("over_priority_level", int'(level_w), 1);
      drive(0, 1, 0, 0, 0);
      chk("over_start_state", int'(state_w), 1);
      chk("over_start_level", int'(level_w), 0);
      chk("over_start_cd", int'(cd_w), 3);

      for (int i = 0; i < CD_TICKS; i++) drive(1, 0, 0, 0, 0);
      food_n(12);
      chk("pre_reset_level", int'(level_w), 3);
      bt_n(4);
      drive(1, 0, 0, 0, 0);
      chk("pre_reset_tick", int'(game_tick_w), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_tick", int'(game_tick_w), 0);
      chk("async_reset_state", int'(state_w), 0);
      chk("async_reset_level", int'(level_w), 0);
      chk("async_reset_cd", int'(cd_w), 0);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      t0 = tick_cnt;
      bt_n(10);
      chk("post_reset_no_tick", tick_cnt - t0, 0);
      chk("post_reset_idle", int'(state_w), 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 SHALL have parameter START_DIV, default 8: base ticks per game tick at speed level 0.
REQ-002 SHALL have parameter MIN_DIV, default 2: fastest divisor (floor), with 1 <= MIN_DIV <= START_DIV <= 15.
REQ-003 SHALL have parameter FOOD_PER_LEVEL, default 4: food events per level increment (1..15).
REQ-004 SHALL have parameter COUNTDOWN_TICKS, default 3: base ticks spent in COUNTDOWN (1..3).
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port base_tick, input, 1: one-cycle pulse from the tick divider.
REQ-008 SHALL have port start, input, 1: one-cycle pulse requesting a new game.
REQ-009 SHALL have port pause_btn, input, 1: one-cycle debounced pulse that toggles pause.
REQ-010 SHALL have port food_eaten, input, 1: one-cycle pulse, snake ate food.
REQ-011 SHALL have port game_over, input, 1: level or pulse; collision detected.
REQ-012 SHALL have port game_tick, output, 1: registered one-cycle pulse that advances the snake.
REQ-013 SHALL have port state, output, 3: IDLE=0, COUNTDOWN=1, RUN=2, PAUSED=3, OVER=4.
REQ-014 SHALL have port speed_level, output, 4: current level, 0..MAX_LEVEL, where MAX_LEVEL = START_DIV-MIN_DIV.
REQ-015 SHALL have port countdown, output, 2: remaining countdown value; 0 outside COUNTDOWN.

Function
REQ-016 SHALL compute the divisor as START_DIV - speed_level; it never drops below MIN_DIV.
REQ-017 IDLE: on start, go to COUNTDOWN and load countdown = COUNTDOWN_TICKS; ignore all other inputs.
REQ-018 COUNTDOWN: each base_tick decrements countdown; a base_tick while countdown == 1 enters RUN with countdown = 0 and sub_cnt = 0.
REQ-019 RUN: on base_tick, if sub_cnt >= divisor-1, set game_tick high for exactly the next cycle and clear sub_cnt; otherwise increment sub_cnt.
REQ-020 game_tick latency SHALL be one clk after the qualifying base_tick; game_tick is 0 in every state other than RUN.
REQ-021 RUN: food_eaten increments food_cnt; at FOOD_PER_LEVEL-1 it instead clears food_cnt and increments speed_level.
REQ-022 speed_level SHALL saturate at MAX_LEVEL; food_cnt still wraps at saturation.
REQ-023 A new divisor SHALL take effect from the next base_tick; sub_cnt is not cleared on a level change; the >= compare fires immediately if sub_cnt has already passed the new limit.
REQ-024 If base_tick and food_eaten arrive in the same cycle, the tick decision SHALL use the pre-increment divisor.
REQ-025 RUN: pause_btn enters PAUSED; PAUSED: pause_btn returns to RUN. sub_cnt, food_cnt and speed_level are held in both directions.
REQ-026 PAUSED SHALL ignore base_tick and food_eaten.
REQ-027 pause_btn and base_tick in the same RUN cycle: the pause SHALL win and no game_tick is issued.
REQ-028 game_over in RUN or PAUSED SHALL go to OVER, with priority over pause_btn, food_eaten and base_tick in that cycle; it is ignored in IDLE and COUNTDOWN.
REQ-029 OVER: speed_level is held for display; on start, clear speed_level, food_cnt and sub_cnt, then go to COUNTDOWN.
REQ-030 start in COUNTDOWN, RUN or PAUSED SHALL be ignored.
REQ-031 Any unused state encoding SHALL return to IDLE on the next clk.

Reset
REQ-032 While reset is high, asynchronously: state = IDLE; game_tick, speed_level, countdown, sub_cnt and food_cnt = 0.
REQ-033 Reset asserted mid-game SHALL abort immediately, with no residual game_tick after release.
REQ-034 After release, the block SHALL wait in IDLE for start, regardless of base_tick activity.

Verification
REQ-035 Defaults; start; 3 base_ticks -> countdown 3,2,1 then state=RUN; the next 8 base_ticks -> exactly one game_tick, 1 clk after the 8th.
REQ-036 In RUN, 4 food_eaten pulses -> speed_level=1 and game_tick every 7 base_ticks; 28 more pulses -> speed_level saturates at 6, divisor 2.
REQ-037 sub_cnt=5 at level 2 (divisor 6), then food raises the level to 3 (divisor 5) -> game_tick on the very next base_tick.
REQ-038 pause_btn coincident with base_tick at sub_cnt=7 -> no game_tick and state=PAUSED; 20 base_ticks produce nothing; pause_btn then 1 base_tick -> game_tick.
REQ-039 game_over plus pause_btn plus food_eaten in one PAUSED cycle -> state=OVER with speed_level unchanged; start -> COUNTDOWN with speed_level=0.
REQ-040 Reset pulse mid-RUN at level 3 -> all outputs 0 and state=IDLE asynchronously; base_ticks with no start -> no game_tick.
